// File: rtl/add8_share_sched.sv
// Purpose : round-robin share of one 8-bit add stage (a+b+cin) among NREQ requesters; beats may chain carries under a lock.
// Latency : 1 cycle from accept (req_valid & req_ready) to rsp_valid; one beat per cycle sustained.
// Backpr. : when the response register is held (rsp_valid & !rsp_ready) every req_ready is low.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_valid/req_ready[NREQ]     per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b[NREQ*8]           operands, requester i at [8i+7:8i]
//   req_cin/req_chain[NREQ]       carry-in on a first beat / hold lock after this beat
//   rsp_valid/rsp_ready           response handshake
//   rsp_id, rsp_sum, rsp_cout     tagged 8-bit result and carry-out
//   busy                          in LOCK or a response is pending
//   lock_abort                    one-cycle pulse when an idle lock is force-released
module add8_share_sched #(
  parameter int NREQ     = 4,
  parameter int ID_W     = 2,
  parameter int LOCK_TMO = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  input  logic [NREQ-1:0]   req_chain,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [7:0]        rsp_sum,
  output logic              rsp_cout,
  output logic              busy,
  output logic              lock_abort
);

  localparam int TW = $clog2(LOCK_TMO + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state, state_nx;
  logic [ID_W-1:0] owner;
  logic [ID_W-1:0] last;
  logic            carry;
  logic [TW-1:0]   tmo_cnt;

  logic            open;
  logic            gnt_vld;
  logic [ID_W-1:0] gnt;
  logic [ID_W-1:0] idx;
  logic            tmo_hit;
  logic [7:0]      a_arr [NREQ];
  logic [7:0]      b_arr [NREQ];
  logic            cin_g;
  logic            chain_g;
  logic [8:0]      sum9;

  assign open = !rsp_valid || rsp_ready;
  assign busy = (state == LOCK) || rsp_valid;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = req_a[i*8 +: 8];
      b_arr[i] = req_b[i*8 +: 8];
    end
  end

  // Grant: the lock owner only while locked, otherwise the first valid
  // requester after the last one served (wrapping modulo NREQ).
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    if (open) begin
      if (state == LOCK) begin
        if (req_valid[owner]) begin
          gnt_vld = 1'b1;
          gnt     = owner;
        end
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = ID_W'((int'(last) + k) % NREQ);
          if (!gnt_vld && req_valid[idx]) begin
            gnt_vld = 1'b1;
            gnt     = idx;
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[gnt] = 1'b1;
  end

  // Locked beats continue the stored carry; req_cin only starts a new operation.
  assign cin_g   = (state == LOCK) ? carry : req_cin[gnt];
  assign chain_g = req_chain[gnt];
  assign sum9    = {1'b0, a_arr[gnt]} + {1'b0, b_arr[gnt]} + {8'd0, cin_g};

  // An owner accept in the expiry cycle takes priority over the abort.
  assign tmo_hit = (state == LOCK) && !gnt_vld && (tmo_cnt == TW'(LOCK_TMO - 1));

  always_comb begin
    state_nx = state;
    if (gnt_vld) begin
      state_nx = chain_g ? LOCK : IDLE;
    end else if (tmo_hit) begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= '0;
      last       <= ID_W'(NREQ - 1);
      carry      <= 1'b0;
      tmo_cnt    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      lock_abort <= 1'b0;
    end else begin
      lock_abort <= 1'b0;
      if (gnt_vld) begin
        rsp_valid <= 1'b1;
        rsp_id    <= gnt;
        rsp_sum   <= sum9[7:0];
        rsp_cout  <= sum9[8];
        tmo_cnt   <= '0;
        if (chain_g) begin
          owner <= gnt;
          carry <= sum9[8];
        end else begin
          last  <= gnt;
          carry <= 1'b0;
        end
      end else begin
        if (rsp_ready) rsp_valid <= 1'b0;
        if (state == LOCK) begin
          // Stalled cycles count too: a lock cannot pin the adder indefinitely.
          if (tmo_hit) begin
            last       <= owner;
            carry      <= 1'b0;
            tmo_cnt    <= '0;
            lock_abort <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_add8_share_sched.sv
module tb_add8_share_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_cin = '0;
  logic [3:0]  req_chain = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_sum;
  logic        rsp_cout;
  logic        busy;
  logic        lock_abort;

  int n_cmp = 0;
  int n_err = 0;

  add8_share_sched #(.NREQ(4), .ID_W(2), .LOCK_TMO(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_chain(req_chain),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .busy(busy), .lock_abort(lock_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic chain);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_cin[i]      = cin;
    req_chain[i]    = chain;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id,
                         input logic [7:0] sum, input logic cout);
    chk({tag, "_vld"},  32'(rsp_valid), 32'(1));
    chk({tag, "_id"},   32'(rsp_id),    32'(id));
    chk({tag, "_sum"},  32'(rsp_sum),   32'(sum));
    chk({tag, "_cout"}, 32'(rsp_cout),  32'(cout));
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_rsp_valid",  32'(rsp_valid),  32'(0));
    chk("rst_rsp_sum",    32'(rsp_sum),    32'(0));
    chk("rst_busy",       32'(busy),       32'(0));
    chk("rst_lock_abort", 32'(lock_abort), 32'(0));
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();

    // Round robin from reset: 0,1,2,3,0,1 back to back
    for (int i = 0; i < 4; i++) set_req(i, 8'(8'h10 * i + 1), 8'(i), 1'b0, 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick();
      chk_rsp("rr_rsp", 2'(k % 4), 8'(8'h10 * (k % 4) + 1 + (k % 4)), 1'b0);
    end
    req_valid = '0;
    tick();
    chk("rr_drain", 32'(rsp_valid), 32'(0));

    // Single beat: 0x5A + 0x33 + 1 = 0x8E
    set_req(2, 8'h5A, 8'h33, 1'b1, 1'b0);
    req_valid = 4'b0100;
    #1;
    chk("sb_ready", 32'(req_ready), 32'(4'b0100));
    tick();
    req_valid = '0;
    chk_rsp("sb_rsp", 2'd2, 8'h8E, 1'b0);
    chk("sb_busy", 32'(busy), 32'(1));
    tick();
    chk("sb_idle_busy", 32'(busy), 32'(0));

    // Chained 16-bit: 0x12FF + 0x0001 = 0x1300
    set_req(1, 8'hFF, 8'h01, 1'b0, 1'b1);
    req_valid = 4'b0010;
    #1;
    chk("ch0_ready", 32'(req_ready), 32'(4'b0010));
    tick();
    chk_rsp("ch0_rsp", 2'd1, 8'h00, 1'b1);
    set_req(0, 8'h20, 8'h30, 1'b1, 1'b0);
    req_valid = 4'b0001;
    #1;
    chk("ch_lock_block", 32'(req_ready), 32'(0));
    tick();
    set_req(1, 8'h12, 8'h00, 1'b0, 1'b0);
    req_valid = 4'b0011;
    #1;
    chk("ch1_ready", 32'(req_ready), 32'(4'b0010));
    tick();
    chk_rsp("ch1_rsp", 2'd1, 8'h13, 1'b0);
    req_valid = 4'b0001;
    #1;
    chk("ch_rel_ready", 32'(req_ready), 32'(4'b0001));
    tick();
    chk_rsp("ch_rel_rsp", 2'd0, 8'h51, 1'b0);

    // Backpressure with response from req 0 pending
    req_valid = 4'b1000;
    set_req(3, 8'h80, 8'h80, 1'b1, 1'b0);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'(0));
      tick();
      chk_rsp("bp_hold", 2'd0, 8'h51, 1'b0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_reload_ready", 32'(req_ready), 32'(4'b1000));
    tick();
    chk_rsp("bp_reload", 2'd3, 8'h01, 1'b1);
    req_valid = '0;
    tick();
    chk("bp_drain", 32'(rsp_valid), 32'(0));

    // Lock timeout: req 2 locks then goes quiet
    set_req(2, 8'hF0, 8'h10, 1'b0, 1'b1);
    req_valid = 4'b0100;
    #1;
    chk("to_ready", 32'(req_ready), 32'(4'b0100));
    tick();
    req_valid = '0;
    chk_rsp("to_lock_rsp", 2'd2, 8'h00, 1'b1);
    repeat (14) begin
      tick();
      chk("to_no_abort", 32'(lock_abort), 32'(0));
    end
    chk("to_busy_locked", 32'(busy), 32'(1));
    tick();
    chk("to_abort", 32'(lock_abort), 32'(1));
    chk("to_busy_idle", 32'(busy), 32'(0));
    set_req(2, 8'h01, 8'h01, 1'b0, 1'b0);
    set_req(3, 8'h05, 8'h06, 1'b0, 1'b0);
    req_valid = 4'b1100;
    #1;
    chk("to_next_ready", 32'(req_ready), 32'(4'b1000));
    tick();
    chk("to_abort_once", 32'(lock_abort), 32'(0));
    chk_rsp("to_next_rsp", 2'd3, 8'h0B, 1'b0);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    chk_rsp("to_cin_rsp", 2'd2, 8'h02, 1'b0);
    tick();

    // Async reset in the middle of a lock with a response pending
    set_req(1, 8'h01, 8'h01, 1'b0, 1'b1);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    chk_rsp("ar_pre", 2'd1, 8'h02, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("ar_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("ar_rsp_id",    32'(rsp_id),    32'(0));
    chk("ar_rsp_sum",   32'(rsp_sum),   32'(0));
    chk("ar_busy",      32'(busy),      32'(0));
    tick();
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'h10, 1'b0, 1'b0);
    req_valid = 4'b1111;
    #1;
    chk("ar_first_ready", 32'(req_ready), 32'(4'b0001));
    tick();
    req_valid = '0;
    chk_rsp("ar_first_rsp", 2'd0, 8'h11, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
